gate_bist_ctrl: RTL and testbench

GATE_BIST_CTRL -- requirements
Module: gate_bist_ctrl

---
 rtl/gate_bist_ctrl.sv | 140 ++++++++++++++
 tb/tb_gate_bist_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_bist_ctrl.sv
// Gate-level BIST controller: applies PAT_W-bit patterns, compacts responses into a 16-bit MISR.
// Define GATE_BIST_LFSR_EN to source patterns from a Fibonacci LFSR instead of a binary counter.
module gate_bist_ctrl #(
    parameter int PAT_W  = 15,
    parameter int RESP_W = 10,
    parameter int SETTLE = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [15:0]       i_num_pat,
    input  logic [15:0]       i_exp_sig,
    output logic [PAT_W-1:0]  o_dut_in,
    input  logic [RESP_W-1:0] i_dut_out,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [15:0]       o_signature
);

    // Counter must hold 2^PAT_W as well as any 16-bit pattern request.
    localparam int CNT_W = (PAT_W + 1 > 17) ? PAT_W + 1 : 17;
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = {{(CNT_W-1){1'b0}}, 1'b1} << PAT_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [SET_W-1:0]   r_settle_cnt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_npat;
    logic [15:0]        r_misr;
    logic [PAT_W-1:0]   r_pat;
    logic               r_done;
    logic               r_pass;
    logic [15:0]        r_sig;

    logic [CNT_W-1:0]   w_npat_ext;
    logic [CNT_W-1:0]   w_npat_eff;
    logic [PAT_W-1:0]   w_next_pat;
    logic [PAT_W-1:0]   w_seed;
    logic [15:0]        w_misr_next;
    logic               w_settle_last;
    logic               w_last_pat;

    assign w_npat_ext = CNT_W'(i_num_pat);
    assign w_npat_eff = ((i_num_pat == 16'd0) || (w_npat_ext > FULL_CNT)) ? FULL_CNT : w_npat_ext;

    assign w_settle_last = (r_settle_cnt == SET_W'(SETTLE - 1));
    assign w_last_pat    = ((r_cnt + CNT_W'(1)) == r_npat);

    assign w_misr_next = {r_misr[14:0], 1'b0}
                       ^ (r_misr[15] ? 16'h100B : 16'h0000)
                       ^ 16'(i_dut_out);

`ifdef GATE_BIST_LFSR_EN
    assign w_seed     = PAT_W'(1);
    assign w_next_pat = {r_pat[PAT_W-2:0], r_pat[PAT_W-1] ^ r_pat[PAT_W-2]};
`else
    assign w_seed     = '0;
    assign w_next_pat = r_pat + PAT_W'(1);
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_next_state = S_SETTLE;
            S_SETTLE:  if (w_settle_last) w_next_state = S_CAPTURE;
            S_CAPTURE: w_next_state = w_last_pat ? S_DONE : S_SETTLE;
            S_DONE:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy      = (r_state != S_IDLE);
        o_done      = r_done;
        o_pass      = r_pass;
        o_signature = r_sig;
        o_dut_in    = r_pat;
    end

    // Datapath; done is registered so it pulses in the IDLE cycle following DONE.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_settle_cnt <= '0;
            r_cnt        <= '0;
            r_npat       <= '0;
            r_misr       <= '0;
            r_pat        <= '0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_sig        <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_npat       <= w_npat_eff;
                        r_cnt        <= '0;
                        r_misr       <= '0;
                        r_pass       <= 1'b0;
                        r_sig        <= '0;
                        r_pat        <= w_seed;
                        r_settle_cnt <= '0;
                    end
                end
                S_SETTLE: begin
                    r_settle_cnt <= w_settle_last ? '0 : r_settle_cnt + SET_W'(1);
                end
                S_CAPTURE: begin
                    r_misr <= w_misr_next;
                    r_pat  <= w_next_pat;
                    r_cnt  <= r_cnt + CNT_W'(1);
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    r_sig  <= r_misr;
                    r_pass <= (r_misr == i_exp_sig);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed self-checking bench for gate_bist_ctrl; a second small instance (PAT_W=8, SETTLE=1)
// covers the full-range pattern count and wrap without a very long run.
module tb_gate_bist_ctrl;

    logic        clk;
    logic        rstN;
    logic        startIn;
    logic [15:0] numPatIn;
    logic [15:0] expSigIn;
    logic [9:0]  dutOutIn;

    logic [14:0] dutInM;
    logic        busyM, doneM, passM;
    logic [15:0] sigM;

    logic [7:0]  dutInS;
    logic        busyS, doneS, passS;
    logic [15:0] sigS;

    bit          useSmall;
    logic [15:0] obsDutIn;
    logic        obsBusy, obsDone, obsPass;
    logic [15:0] obsSig;

    int checks   = 0;
    int failures = 0;
    logic [15:0] seenPat [0:15];

`ifdef GATE_BIST_LFSR_EN
    localparam logic [15:0] EXP_P0 = 16'h0001;
    localparam logic [15:0] EXP_P1 = 16'h0002;
    localparam logic [15:0] EXP_P2 = 16'h0004;
`else
    localparam logic [15:0] EXP_P0 = 16'h0000;
    localparam logic [15:0] EXP_P1 = 16'h0001;
    localparam logic [15:0] EXP_P2 = 16'h0002;
`endif

    gate_bist_ctrl dutMain (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_start     (startIn),
        .i_num_pat   (numPatIn),
        .i_exp_sig   (expSigIn),
        .o_dut_in    (dutInM),
        .i_dut_out   (dutOutIn),
        .o_busy      (busyM),
        .o_done      (doneM),
        .o_pass      (passM),
        .o_signature (sigM)
    );

    gate_bist_ctrl #(.PAT_W(8), .RESP_W(10), .SETTLE(1)) dutSmall (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_start     (startIn),
        .i_num_pat   (numPatIn),
        .i_exp_sig   (expSigIn),
        .o_dut_in    (dutInS),
        .i_dut_out   (dutOutIn),
        .o_busy      (busyS),
        .o_done      (doneS),
        .o_pass      (passS),
        .o_signature (sigS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        obsDutIn = useSmall ? 16'(dutInS) : 16'(dutInM);
        obsBusy  = useSmall ? busyS : busyM;
        obsDone  = useSmall ? doneS : doneM;
        obsPass  = useSmall ? passS : passM;
        obsSig   = useSmall ? sigS  : sigM;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a run, samples the pattern shown after each capture, returns edges to done (-1 on timeout).
    task automatic applyStimulus(input logic [15:0] numPat, input logic [9:0] dutOut,
                                 input logic [15:0] expSig, input bit holdStart,
                                 input int bound, output int latency);
        int  lat;
        int  period;
        bit  seenDone;
        period   = useSmall ? 2 : 4 - 1;
        numPatIn = numPat;
        dutOutIn = dutOut;
        expSigIn = expSig;
        startIn  = 1'b1;
        tick();
        if (!holdStart) startIn = 1'b0;
        for (int k = 0; k < 16; k++) seenPat[k] = 16'hDEAD;
        seenPat[0] = obsDutIn;
        lat      = 0;
        seenDone = 1'b0;
        while (!seenDone && lat < bound) begin
            tick();
            lat++;
            if ((lat % period) == 0 && (lat / period) < 16) seenPat[lat / period] = obsDutIn;
            if (obsDone) seenDone = 1'b1;
        end
        startIn = 1'b0;
        latency = seenDone ? lat : -1;
    endtask

    initial begin
        int          lat;
        int          doneCount;
        logic [7:0]  lfsrModel;
        logic [15:0] expWrap;

        useSmall = 1'b0;
        rstN     = 1'b0;
        startIn  = 1'b1;
        numPatIn = 16'd1;
        expSigIn = 16'h0000;
        dutOutIn = 10'h3FF;

        // Reset held with start asserted
        repeat (3) tick();
        checkOutput("rst_busy", 32'(busyM), 32'd0);
        checkOutput("rst_done", 32'(doneM), 32'd0);
        checkOutput("rst_pass", 32'(passM), 32'd0);
        checkOutput("rst_sig", 32'(sigM), 32'd0);
        checkOutput("rst_dutin", 32'(dutInM), 32'd0);
        rstN    = 1'b1;
        startIn = 1'b0;
        tick();
        checkOutput("rst_release_busy", 32'(busyM), 32'd0);

        // Single pattern, all-ones response
        applyStimulus(16'd1, 10'h3FF, 16'h03FF, 1'b0, 200, lat);
        checkOutput("one_pat0", 32'(seenPat[0]), 32'(EXP_P0));
        checkOutput("one_latency", 32'(lat), 32'd4);
        checkOutput("one_busy_at_done", 32'(busyM), 32'd0);
        checkOutput("one_sig", 32'(sigM), 32'h03FF);
        checkOutput("one_pass", 32'(passM), 32'd1);
        tick();
        checkOutput("one_done_width", 32'(doneM), 32'd0);
        checkOutput("one_sig_held", 32'(sigM), 32'h03FF);

        // Two patterns, pass
        applyStimulus(16'd2, 10'h001, 16'h0003, 1'b0, 200, lat);
        checkOutput("two_pat0", 32'(seenPat[0]), 32'(EXP_P0));
        checkOutput("two_pat1", 32'(seenPat[1]), 32'(EXP_P1));
        checkOutput("two_latency", 32'(lat), 32'd7);
        checkOutput("two_sig", 32'(sigM), 32'h0003);
        checkOutput("two_pass", 32'(passM), 32'd1);
        tick();

        // Two patterns, wrong expected signature
        applyStimulus(16'd2, 10'h001, 16'h0002, 1'b0, 200, lat);
        checkOutput("fail_latency", 32'(lat), 32'd7);
        checkOutput("fail_sig", 32'(sigM), 32'h0003);
        checkOutput("fail_pass", 32'(passM), 32'd0);
        tick();

        // start held high through the run and DONE must not retrigger
        applyStimulus(16'd2, 10'h001, 16'h0003, 1'b1, 200, lat);
        checkOutput("hold_latency", 32'(lat), 32'd7);
        checkOutput("hold_busy_at_done", 32'(busyM), 32'd0);
        checkOutput("hold_pass", 32'(passM), 32'd1);
        tick();
        checkOutput("hold_busy_after", 32'(busyM), 32'd0);
        checkOutput("hold_done_after", 32'(doneM), 32'd0);

        // Three patterns: sequence check
        applyStimulus(16'd3, 10'h001, 16'h0007, 1'b0, 200, lat);
        checkOutput("three_pat0", 32'(seenPat[0]), 32'(EXP_P0));
        checkOutput("three_pat1", 32'(seenPat[1]), 32'(EXP_P1));
        checkOutput("three_pat2", 32'(seenPat[2]), 32'(EXP_P2));
        checkOutput("three_latency", 32'(lat), 32'd10);
        checkOutput("three_sig", 32'(sigM), 32'h0007);
        tick();

        // Eight patterns with MISR feedback taps exercised
        applyStimulus(16'd8, 10'h3FF, 16'h445E, 1'b0, 200, lat);
        checkOutput("eight_latency", 32'(lat), 32'd25);
        checkOutput("eight_sig", 32'(sigM), 32'h445E);
        checkOutput("eight_pass", 32'(passM), 32'd1);
        tick();

        // Reset in the middle of a 100-pattern run
        numPatIn  = 16'd100;
        dutOutIn  = 10'h155;
        startIn   = 1'b1;
        tick();
        startIn   = 1'b0;
        doneCount = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (doneM) doneCount++;
        end
        checkOutput("abort_busy_before", 32'(busyM), 32'd1);
        rstN = 1'b0;
        tick();
        checkOutput("abort_busy", 32'(busyM), 32'd0);
        checkOutput("abort_dutin", 32'(dutInM), 32'd0);
        checkOutput("abort_sig", 32'(sigM), 32'd0);
        checkOutput("abort_pass", 32'(passM), 32'd0);
        rstN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (doneM) doneCount++;
        end
        checkOutput("abort_no_done", 32'(doneCount), 32'd0);
        applyStimulus(16'd1, 10'h3FF, 16'h03FF, 1'b0, 200, lat);
        checkOutput("after_abort_pat0", 32'(seenPat[0]), 32'(EXP_P0));
        checkOutput("after_abort_latency", 32'(lat), 32'd4);
        checkOutput("after_abort_sig", 32'(sigM), 32'h03FF);
        checkOutput("after_abort_pass", 32'(passM), 32'd1);
        tick();

        // Full-range run on the small instance: num_pat=0 and num_pat above 2^PAT_W
`ifdef GATE_BIST_LFSR_EN
        lfsrModel = 8'h01;
        for (int i = 0; i < 256; i++) lfsrModel = {lfsrModel[6:0], lfsrModel[7] ^ lfsrModel[6]};
        expWrap = 16'(lfsrModel);
`else
        expWrap = 16'h0000;
        lfsrModel = 8'h00;
`endif
        useSmall = 1'b1;
        applyStimulus(16'd0, 10'h000, 16'h0000, 1'b0, 1000, lat);
        checkOutput("full_latency", 32'(lat), 32'd513);
        checkOutput("full_wrap_dutin", 32'(obsDutIn), 32'(expWrap));
        checkOutput("full_pass", 32'(obsPass), 32'd1);
        tick();
        applyStimulus(16'd300, 10'h000, 16'h0000, 1'b0, 1000, lat);
        checkOutput("over_latency", 32'(lat), 32'd513);
        checkOutput("over_busy_at_done", 32'(obsBusy), 32'd0);
        checkOutput("over_sig", 32'(obsSig), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
